// File: rtl/load_store_unit.sv
// Load/store unit: validates a request, issues one byte-addressed memory access, returns an extended result.
// Latency: accept at edge N, access cycle N..N+1, response from N+1 (rejects respond from N). Holds the response until resp_ready.
// Backpressure: req_ready only in IDLE; no queuing. Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_error,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_byte_write_enable,
    output logic [31:0]              mem_write_data,
    input  logic [31:0]              mem_read_data
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          lat_write;
    logic [2:0]    lat_funct3;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [31:0]   rdata_q;
    logic          error_q;

    logic [2:0]    size_m1;
    logic [AW:0]   end_addr;
    logic          funct_ok;
    logic          range_ok;
    logic          align_ok;
    logic          reject;
    logic [31:0]   load_ext;
    logic [3:0]    store_mask;

    // Request validation happens in the accept cycle so rejects skip ACCESS entirely.
    always_comb begin
        size_m1 = 3'd0;
        case (req_funct3[1:0])
            2'b00:   size_m1 = 3'd0;
            2'b01:   size_m1 = 3'd1;
            default: size_m1 = 3'd3;
        endcase
    end

    always_comb begin
        funct_ok = 1'b0;
        if (req_write) begin
            funct_ok = (req_funct3 <= 3'd2);
        end else begin
            case (req_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: funct_ok = 1'b1;
                default:                      funct_ok = 1'b0;
            endcase
        end
    end

    // Carry out of the end-address sum means the access would wrap past the top of memory.
    assign end_addr = {1'b0, req_addr[AW-1:0]} + (AW+1)'(size_m1);
    assign range_ok = (req_addr[31:AW] == '0) && !end_addr[AW];

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        align_ok = 1'b1;
        case (req_funct3[1:0])
            2'b01:   align_ok = (req_addr[0] == 1'b0);
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end
`else
    assign align_ok = 1'b1;
`endif

    assign reject = !(funct_ok && range_ok && align_ok);

    always_comb begin
        load_ext = 32'd0;
        case (lat_funct3)
            3'b000:  load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001:  load_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b010:  load_ext = mem_read_data;
            3'b100:  load_ext = {24'd0, mem_read_data[7:0]};
            3'b101:  load_ext = {16'd0, mem_read_data[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        store_mask = 4'b0000;
        case (lat_funct3[1:0])
            2'b00:   store_mask = 4'b0001;
            2'b01:   store_mask = 4'b0011;
            2'b10:   store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus all outputs; rst gates every output so reset values appear immediately.
    always_comb begin
        state_nxt             = state;
        req_ready             = 1'b0;
        resp_valid            = 1'b0;
        resp_rdata            = 32'd0;
        resp_error            = 1'b0;
        mem_addr              = '0;
        mem_byte_write_enable = 4'b0000;
        mem_write_data        = 32'd0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_nxt = reject ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                if (!rst) begin
                    mem_addr = lat_addr;
                    if (lat_write) begin
                        mem_byte_write_enable = store_mask;
                        mem_write_data        = lat_wdata;
                    end
                end
            end
            RESP: begin
                if (!rst) begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_error = error_q;
                end
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write  <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr[AW-1:0];
                lat_wdata  <= req_wdata;
                rdata_q    <= 32'd0;
                error_q    <= reject;
            end
            if (state == ACCESS) begin
                rdata_q <= lat_write ? 32'd0 : load_ext;
                error_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, vector table with scoreboard, plus backpressure and reset-abort sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_byte_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic        mem_init;
    logic [32:0] sb [$];

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs [$];

    load_store_unit #(.ADDRESS_WIDTH(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_write             (req_write),
        .req_funct3            (req_funct3),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_rdata            (resp_rdata),
        .resp_error            (resp_error),
        .mem_addr              (mem_addr),
        .mem_byte_write_enable (mem_byte_write_enable),
        .mem_write_data        (mem_write_data),
        .mem_read_data         (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_read_data = {mem[8'(mem_addr + 8'd3)], mem[8'(mem_addr + 8'd2)],
                         mem[8'(mem_addr + 8'd1)], mem[mem_addr]};
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_write_enable[i]) mem[8'(mem_addr + 8'(i))] <= mem_write_data[8*i +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Scoreboard side: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e[32:1]);
                chk("resp_error", {31'd0, resp_error}, {31'd0, e[0]});
            end
        end
    end

    task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic [3:0] em);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_err = ee; v.exp_mask = em;
        vecs.push_back(v);
    endtask

    // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back({v.exp_rdata, v.exp_err});
        issue(v.w, v.f3, v.addr, v.wdata);
        @(negedge clk);
        if (!v.exp_err) begin
            chk("access_mask", {28'd0, mem_byte_write_enable}, {28'd0, v.exp_mask});
            chk("access_addr", {24'd0, mem_addr}, {24'd0, v.addr[7:0]});
            if (v.w) chk("access_wdata", mem_write_data, v.wdata);
            chk("access_no_valid", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
            chk("resp_valid_n1", {31'd0, resp_valid}, 32'd1);
        end else begin
            chk("reject_valid_n", {31'd0, resp_valid}, 32'd1);
            chk("reject_mask", {28'd0, mem_byte_write_enable}, 32'd0);
        end
        drain();
    endtask

    initial begin
        logic [32:0] exp_lh11;
        logic [32:0] exp_lh7f;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b1; rst = 1'b1; mem_init = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
        exp_lh11 = {32'd0, 1'b1};
        exp_lh7f = {32'd0, 1'b1};
`else
        exp_lh11 = {32'hFFFFADBE, 1'b0};
        exp_lh7f = {32'hFFFF807F, 1'b0};
`endif
        //  w     f3     addr         wdata          exp_rdata       err   mask
        add(1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,          1'b0, 4'b1111);
        add(1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF,   1'b0, 4'b0000);
        add(1'b1, 3'd0, 32'h20,  32'h00000080, 32'h0,          1'b0, 4'b0001);
        add(1'b0, 3'd0, 32'h20,  32'h0,        32'hFFFFFF80,   1'b0, 4'b0000);
        add(1'b0, 3'd4, 32'h20,  32'h0,        32'h00000080,   1'b0, 4'b0000);
        add(1'b0, 3'd2, 32'hFE,  32'h0,        32'h0,          1'b1, 4'b0000);
        add(1'b0, 3'd1, 32'h11,  32'h0,        exp_lh11[32:1], exp_lh11[0], 4'b0000);
        add(1'b0, 3'd1, 32'h7F,  32'h0,        exp_lh7f[32:1], exp_lh7f[0], 4'b0000);
        add(1'b0, 3'd5, 32'h7E,  32'h0,        32'h00007F7E,   1'b0, 4'b0000);
        add(1'b1, 3'd1, 32'h40,  32'h1234ABCD, 32'h0,          1'b0, 4'b0011);
        add(1'b0, 3'd2, 32'h40,  32'h0,        32'h4342ABCD,   1'b0, 4'b0000);
        add(1'b0, 3'd2, 32'hFC,  32'h0,        32'hFFFEFDFC,   1'b0, 4'b0000);
        add(1'b0, 3'd0, 32'hFF,  32'h0,        32'hFFFFFFFF,   1'b0, 4'b0000);
        add(1'b0, 3'd1, 32'hFF,  32'h0,        32'h0,          1'b1, 4'b0000);
        add(1'b0, 3'd3, 32'h00,  32'h0,        32'h0,          1'b1, 4'b0000);
        add(1'b0, 3'd6, 32'h00,  32'h0,        32'h0,          1'b1, 4'b0000);
        add(1'b1, 3'd4, 32'h00,  32'h55,       32'h0,          1'b1, 4'b0000);
        add(1'b0, 3'd2, 32'h100, 32'h0,        32'h0,          1'b1, 4'b0000);
        add(1'b1, 3'd2, 32'hFD,  32'h01020304, 32'h0,          1'b1, 4'b0000);
        add(1'b1, 3'd0, 32'hFF,  32'h000000AA, 32'h0,          1'b0, 4'b0001);
        add(1'b0, 3'd4, 32'hFF,  32'h0,        32'h000000AA,   1'b0, 4'b0000);

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mask", {28'd0, mem_byte_write_enable}, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response held under backpressure while a second request waits.
        resp_ready = 1'b0;
        sb.push_back({32'h00000005, 1'b0});
        issue(1'b0, 3'd4, 32'h05, 32'h0);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd4; req_addr = 32'h06; req_wdata = 32'h0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("bp_resp_seen", {31'd0, resp_valid}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_rdata", resp_rdata, 32'h00000005);
            chk("bp_hold_error", {31'd0, resp_error}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        sb.push_back({32'h00000006, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("bp_back_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Reset in the middle of a store's access cycle.
        issue(1'b1, 3'd2, 32'h30, 32'h11223344);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mask", {28'd0, mem_byte_write_enable}, 32'd0);
        chk("rstmid_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        begin
            vec_t v;
            v.w = 1'b0; v.f3 = 3'd2; v.addr = 32'h30; v.wdata = 32'h0;
            v.exp_rdata = 32'h33323130; v.exp_err = 1'b0; v.exp_mask = 4'b0000;
            run_vec(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning the byte-address width of the downstream data memory.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  access request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32 size/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  consumer takes response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_error  output  1  access rejected, no memory effect.
REQ-014 SHALL have port mem_addr  output  ADDRESS_WIDTH  byte address to data memory.
REQ-015 SHALL have port mem_byte_write_enable  output  4  per-byte write mask; bit i writes byte at mem_addr+i.
REQ-016 SHALL have port mem_write_data  output  32  store data; byte i on bits 8i+7:8i.
REQ-017 SHALL have port mem_read_data  input  32  combinational read of bytes mem_addr..mem_addr+3.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-019 SHALL latch write, funct3, addr, wdata on req_valid && req_ready and enter ACCESS, or enter RESP directly with resp_error=1 if the request is rejected (REQ-022 to REQ-024).
REQ-020 SHALL, in ACCESS (exactly one cycle), drive mem_addr = latched addr[ADDRESS_WIDTH-1:0]; stores: mask SB 0001, SH 0011, SW 1111, mem_write_data = latched wdata; loads: mask 0000.
REQ-021 SHALL, at the ACCESS clock edge, capture load result: LB 000 sign-extend bits 7:0, LH 001 sign-extend 15:0, LW 010 all 32, LBU 100 zero-extend 7:0, LHU 101 zero-extend 15:0.
REQ-022 SHALL reject funct3 3, 6, 7 for loads and funct3 above 2 for stores.
REQ-023 SHALL reject when req_addr[31:ADDRESS_WIDTH] is nonzero or addr + size - 1 exceeds 2**ADDRESS_WIDTH - 1; no wrap-around access is ever issued.
REQ-024 SHALL drive mem_byte_write_enable = 0000 in every state other than ACCESS and whenever rst is high.
REQ-025 SHALL hold resp_valid, resp_rdata, resp_error stable in RESP until resp_ready; return to IDLE on the edge where resp_valid && resp_ready.
REQ-026 SHALL have latency: request accepted at edge N, memory write at edge N+1, resp_valid high from edge N+1 (N for rejected requests); throughput one access per 3 cycles with resp_ready tied high.
REQ-027 SHALL ignore req_valid outside IDLE; requests are not queued.

Reset
REQ-028 SHALL, while rst is high, go to IDLE with resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_byte_write_enable=0000, mem_write_data=0.
REQ-029 SHALL abandon any in-flight access when rst asserts mid-operation: no write issued, no response produced.

Configuration
REQ-030 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, reject halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, perform misaligned accesses directly as byte-addressed accesses at addr..addr+size-1.

Verification
REQ-032 SHALL cover: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> one ACCESS cycle with mask 1111; load response rdata 0xDEADBEEF, error 0.
REQ-033 SHALL cover: SB addr 0x20 wdata 0x00000080, then LB 0x20 -> rdata 0xFFFFFF80; LBU 0x20 -> rdata 0x00000080.
REQ-034 SHALL cover: LW addr 0xFE with ADDRESS_WIDTH=8 -> resp_error 1, rdata 0, mask stays 0000, resp_valid at the edge after accept.
REQ-035 SHALL cover: LH addr 0x11 -> error 1 with LSU_MISALIGN_TRAP_EN; without the macro, rdata equals sign-extended bytes 0x12:0x11.
REQ-036 SHALL cover: resp_ready low for 3 cycles with a new req_valid pending -> response held stable, req_ready 0, pending request accepted only after return to IDLE.
REQ-037 SHALL cover: rst asserted during ACCESS of SW 0x30 -> mask 0000 at that edge, no response, IDLE next cycle.
